// File: rtl/pmsm_ctrl_pkg.sv
// Shared definitions for the PMSM speed controller.
//   state_t   : controller FSM states (exposed on the top for debug)
//   widths    : speed, error, gain, integrator and multiplier widths
//   sat_u12() : clamps a signed control value to the unsigned 12-bit drive range
package pmsm_ctrl_pkg;

  localparam int SPD_W     = 12;
  localparam int ERR_W     = 13;
  localparam int GAIN_W    = 8;
  localparam int INT_W     = 20;
  localparam int FRAC_BITS = 4;
  localparam int MUL_W     = ERR_W + GAIN_W;     // full signed product width
  localparam int PROD_W    = MUL_W - FRAC_BITS;  // product after the Q4.4 shift

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_ERR,
    ST_MULP,
    ST_MULI,
    ST_SUM,
    ST_WRITE,
    ST_FAULT
  } state_t;

  localparam logic signed [MUL_W-1:0] U_MAX = 21'sd4095;

  function automatic logic [SPD_W-1:0] sat_u12(input logic signed [MUL_W-1:0] v);
    if (v[MUL_W-1]) begin
      return '0;
    end else if (v > U_MAX) begin
      return '1;
    end else begin
      return SPD_W'(v);
    end
  endfunction

endpackage

// File: rtl/pmsm_mul_q44.sv
// Signed error times unsigned Q4.4 gain, scaled back by FRAC_BITS.
// Purely combinational; the controller shares one instance between kp and ki.
//   i_a : signed error (ERR_W)
//   i_b : unsigned Q4.4 gain (GAIN_W)
//   o_y : (i_a * i_b) >>> FRAC_BITS, signed PROD_W
module pmsm_mul_q44
  import pmsm_ctrl_pkg::*;
(
  input  logic signed [ERR_W-1:0]  i_a,
  input  logic        [GAIN_W-1:0] i_b,
  output logic signed [PROD_W-1:0] o_y
);

  logic signed [MUL_W-1:0] w_a_ext;
  logic signed [MUL_W-1:0] w_b_ext;
  logic signed [MUL_W-1:0] w_prod;

  // The true product of a 13-bit signed and a 9-bit non-negative value
  // always fits in MUL_W signed bits, so no overflow handling is needed.
  assign w_a_ext = {{GAIN_W{i_a[ERR_W-1]}}, i_a};
  assign w_b_ext = {{ERR_W{1'b0}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;
  assign o_y     = PROD_W'(w_prod >>> FRAC_BITS);

endmodule

// File: rtl/pmsm_speed_ctrl.sv
// Closed-loop PI speed controller for the PMSM motor model.
// Each control tick runs SAMPLE -> ERR -> MULP -> MULI -> SUM -> WRITE.
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   i_enable           : run the loop; low idles and clears the loop state
//   i_speed_ref        : target speed (unsigned 12)
//   i_kp, i_ki         : unsigned Q4.4 gains
//   i_fault_clr        : clears the overspeed fault while i_enable is low
//   i_motor_speed      : measured speed from the motor model
//   o_phase_voltage    : drive to the motor model
//   o_update_valid     : single-cycle pulse in the cycle o_phase_voltage shows
//                        a newly written value (no back-pressure; the consumer
//                        must take it in that cycle)
//   o_busy             : loop in progress (not IDLE or FAULT)
//   o_fault            : latched overspeed flag
//   o_ref_eff          : slew-limited reference
//   o_state            : FSM state, for debug
module pmsm_speed_ctrl
  import pmsm_ctrl_pkg::*;
#(
  parameter int CTRL_DIV  = 64,
  parameter int RAMP_STEP = 16,
  parameter int INT_LIM   = 4095,
  parameter int OVERSPEED = 3800
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [SPD_W-1:0]  i_speed_ref,
  input  logic [GAIN_W-1:0] i_kp,
  input  logic [GAIN_W-1:0] i_ki,
  input  logic              i_fault_clr,
  input  logic [SPD_W-1:0]  i_motor_speed,
  output logic [SPD_W-1:0]  o_phase_voltage,
  output logic              o_update_valid,
  output logic              o_busy,
  output logic              o_fault,
  output logic [SPD_W-1:0]  o_ref_eff,
  output state_t            o_state
);

  localparam int                      DIV_W    = $clog2(CTRL_DIV);
  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(CTRL_DIV - 1);
  localparam logic [SPD_W-1:0]        STEP     = SPD_W'(RAMP_STEP);
  localparam logic [SPD_W-1:0]        OVS      = SPD_W'(OVERSPEED);
  localparam logic signed [MUL_W-1:0] INT_MAX  = MUL_W'(INT_LIM);
  localparam logic signed [MUL_W-1:0] INT_MIN  = -INT_MAX;

  state_t                    r_state;
  state_t                    w_next;
  logic [DIV_W-1:0]          r_div;
  logic [SPD_W-1:0]          r_speed;
  logic [SPD_W-1:0]          r_ref;
  logic signed [ERR_W-1:0]   r_err;
  logic signed [PROD_W-1:0]  r_p;
  logic signed [PROD_W-1:0]  r_inc;
  logic signed [INT_W-1:0]   r_integ;
  logic [SPD_W-1:0]          r_u_sat;
  logic [SPD_W-1:0]          r_pv;
  logic                      r_uv;
  logic                      r_fault;

  logic                      w_tick;
  logic                      w_overspeed;
  logic                      w_abort;
  logic [SPD_W-1:0]          w_ref_next;
  logic [GAIN_W-1:0]         w_gain;
  logic signed [PROD_W-1:0]  w_mul;
  logic signed [MUL_W-1:0]   w_u;
  logic signed [MUL_W-1:0]   w_integ_sum;
  logic signed [MUL_W-1:0]   w_integ_clamped;
  logic                      w_hold;

  assign w_tick      = (r_div == DIV_LAST);
  assign w_overspeed = (i_motor_speed > OVS);
  // Dropping enable abandons any loop in progress, but never leaves FAULT.
  assign w_abort     = !i_enable && (r_state != ST_FAULT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div <= '0;
    end else if (!i_enable || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_tick) w_next = ST_SAMPLE;
        ST_SAMPLE: w_next = w_overspeed ? ST_FAULT : ST_ERR;
        ST_ERR:    w_next = ST_MULP;
        ST_MULP:   w_next = ST_MULI;
        ST_MULI:   w_next = ST_SUM;
        ST_SUM:    w_next = ST_WRITE;
        ST_WRITE:  w_next = ST_IDLE;
        ST_FAULT:  if (!i_enable && i_fault_clr) w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  // Slew limiter: step toward the target, landing exactly on it.
  always_comb begin
    w_ref_next = i_speed_ref;
    if (i_speed_ref > r_ref) begin
      if ((i_speed_ref - r_ref) > STEP) w_ref_next = r_ref + STEP;
    end else if ((r_ref - i_speed_ref) > STEP) begin
      w_ref_next = r_ref - STEP;
    end
  end

  assign w_gain = (r_state == ST_MULI) ? i_ki : i_kp;

  pmsm_mul_q44 u_mul (
    .i_a (r_err),
    .i_b (w_gain),
    .o_y (w_mul)
  );

  assign w_u         = {{(MUL_W-PROD_W){r_p[PROD_W-1]}}, r_p}
                     + {{(MUL_W-INT_W){r_integ[INT_W-1]}}, r_integ};
  assign w_integ_sum = {{(MUL_W-PROD_W){r_inc[PROD_W-1]}}, r_inc}
                     + {{(MUL_W-INT_W){r_integ[INT_W-1]}}, r_integ};
  assign w_integ_clamped = (w_integ_sum > INT_MAX) ? INT_MAX :
                           (w_integ_sum < INT_MIN) ? INT_MIN : w_integ_sum;
  // Anti-windup: freeze the integrator while the output is saturated and
  // the increment would push it further into saturation.
  assign w_hold = ((!w_u[MUL_W-1] && (w_u > U_MAX)) && !r_inc[PROD_W-1] && (r_inc != '0))
               || (w_u[MUL_W-1] && r_inc[PROD_W-1]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_speed <= '0;
      r_ref   <= '0;
      r_err   <= '0;
      r_p     <= '0;
      r_inc   <= '0;
      r_integ <= '0;
      r_u_sat <= '0;
      r_pv    <= '0;
      r_uv    <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_uv <= 1'b0;
      if (w_abort) begin
        r_pv    <= '0;
        r_integ <= '0;
        r_ref   <= '0;
      end else begin
        case (r_state)
          ST_SAMPLE: begin
            r_speed <= i_motor_speed;
            if (w_overspeed) begin
              r_fault <= 1'b1;
              r_pv    <= '0;
              r_integ <= '0;
              r_ref   <= '0;
            end else begin
              r_ref <= w_ref_next;
            end
          end
          ST_ERR:  r_err <= {1'b0, r_ref} - {1'b0, r_speed};
          ST_MULP: r_p   <= w_mul;
          ST_MULI: r_inc <= w_mul;
          ST_SUM: begin
            r_u_sat <= sat_u12(w_u);
            if (!w_hold) r_integ <= INT_W'(w_integ_clamped);
          end
          ST_WRITE: begin
            r_pv <= r_u_sat;
            r_uv <= 1'b1;
          end
          ST_FAULT: if (!i_enable && i_fault_clr) r_fault <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign o_phase_voltage = r_pv;
  assign o_update_valid  = r_uv;
  assign o_busy          = (r_state != ST_IDLE) && (r_state != ST_FAULT);
  assign o_fault         = r_fault;
  assign o_ref_eff       = r_ref;
  assign o_state         = r_state;

endmodule

// File: tb/tb_pmsm_speed_ctrl.sv
module tb_pmsm_speed_ctrl;
  import pmsm_ctrl_pkg::*;

  localparam int DIV  = 16;
  localparam int RAMP = 64;
  localparam int LIM  = 4095;
  localparam int OVS  = 3800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] speed_ref = '0;
  logic [7:0]  kp = '0;
  logic [7:0]  ki = '0;
  logic        fault_clr = 1'b0;
  logic [11:0] motor_speed = '0;
  logic [11:0] o_phase_voltage;
  logic        o_update_valid;
  logic        o_busy;
  logic        o_fault;
  logic [11:0] o_ref_eff;
  state_t      o_state;

  int errors = 0;
  int checks = 0;

  // Behavioural loop model: reference, integrator and last written drive.
  int m_ref = 0;
  int m_integ = 0;
  int m_pv = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  pmsm_speed_ctrl #(
    .CTRL_DIV  (DIV),
    .RAMP_STEP (RAMP),
    .INT_LIM   (LIM),
    .OVERSPEED (OVS)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_enable        (enable),
    .i_speed_ref     (speed_ref),
    .i_kp            (kp),
    .i_ki            (ki),
    .i_fault_clr     (fault_clr),
    .i_motor_speed   (motor_speed),
    .o_phase_voltage (o_phase_voltage),
    .o_update_valid  (o_update_valid),
    .o_busy          (o_busy),
    .o_fault         (o_fault),
    .o_ref_eff       (o_ref_eff),
    .o_state         (o_state)
  );

  // ---------------- reference model ----------------
  function automatic int fdiv16(input int x);
    if (x >= 0) return x / 16;
    return -((-x + 15) / 16);
  endfunction

  function automatic void model_clear();
    m_ref = 0;
    m_integ = 0;
    m_pv = 0;
  endfunction

  function automatic void model_loop(input int sref, input int ms, input int gp, input int gi);
    int err, p, inc, u, nxt;
    if (sref > m_ref) m_ref = (sref - m_ref > RAMP) ? m_ref + RAMP : sref;
    else if (m_ref - sref > RAMP) m_ref = m_ref - RAMP;
    else m_ref = sref;
    err = m_ref - ms;
    p = fdiv16(err * gp);
    inc = fdiv16(err * gi);
    u = p + m_integ;
    m_pv = (u < 0) ? 0 : ((u > 4095) ? 4095 : u);
    if (!((u > 4095 && inc > 0) || (u < 0 && inc < 0))) begin
      nxt = m_integ + inc;
      if (nxt > LIM) nxt = LIM;
      if (nxt < -LIM) nxt = -LIM;
      m_integ = nxt;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input int sref, input int ms, input int gp, input int gi);
    speed_ref = 12'(sref);
    motor_speed = 12'(ms);
    kp = 8'(gp);
    ki = 8'(gi);
  endtask

  task automatic wait_update(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (o_update_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_state(input state_t st, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (o_state == st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic disable_loop();
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
  endtask

  // Runs one loop with the current inputs and compares drive and reference.
  task automatic run_loop_checked(input string name);
    bit ok;
    wait_update(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout: no update_valid within %0d cycles", name, 4 * DIV);
    end else begin
      model_loop(int'(speed_ref), int'(motor_speed), int'(kp), int'(ki));
      checks++;
      if (o_phase_voltage !== 12'(m_pv)) begin
        errors++;
        $display("FAIL %s phase_voltage: got %0d expected %0d", name, o_phase_voltage, m_pv);
      end
      checks++;
      if (o_ref_eff !== 12'(m_ref)) begin
        errors++;
        $display("FAIL %s ref_eff: got %0d expected %0d", name, o_ref_eff, m_ref);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (o_phase_voltage !== 12'd0) begin errors++; $display("FAIL reset pv: got %0d expected 0", o_phase_voltage); end
    if (o_update_valid !== 1'b0) begin errors++; $display("FAIL reset uv: got %b expected 0", o_update_valid); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", o_busy); end
    if (o_fault !== 1'b0) begin errors++; $display("FAIL reset fault: got %b expected 0", o_fault); end
    if (o_ref_eff !== 12'd0) begin errors++; $display("FAIL reset ref_eff: got %0d expected 0", o_ref_eff); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_state !== ST_IDLE) begin errors++; $display("FAIL reset state: got %0d expected IDLE", o_state); end
    model_clear();
  endtask

  task automatic test_slew();
    set_inputs(1000, 0, 16, 0);
    enable = 1'b1;
    for (int n = 1; n <= 16; n++) run_loop_checked("slew");
    checks++;
    if (o_ref_eff !== 12'd1000) begin
      errors++;
      $display("FAIL slew final ref_eff: got %0d expected 1000", o_ref_eff);
    end
  endtask

  // Drive update lands on the edge that takes the FSM from WRITE back to
  // IDLE: six edges after the edge that entered SAMPLE.
  task automatic test_latency();
    bit ok;
    logic [11:0] old_pv;
    old_pv = o_phase_voltage;
    motor_speed = 12'd200;
    wait_state(ST_SAMPLE, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL latency timeout: SAMPLE never reached");
      return;
    end
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL latency busy: got %b expected 1", o_busy); end
    model_loop(int'(speed_ref), 200, int'(kp), int'(ki));
    repeat (5) @(negedge clk);
    checks += 2;
    if (o_update_valid !== 1'b0) begin errors++; $display("FAIL latency early uv: got %b expected 0", o_update_valid); end
    if (o_phase_voltage !== old_pv) begin errors++; $display("FAIL latency early pv: got %0d expected %0d", o_phase_voltage, old_pv); end
    @(negedge clk);
    checks += 3;
    if (o_update_valid !== 1'b1) begin errors++; $display("FAIL latency uv: got %b expected 1", o_update_valid); end
    if (o_phase_voltage !== 12'(m_pv)) begin errors++; $display("FAIL latency pv: got %0d expected %0d", o_phase_voltage, m_pv); end
    if (o_phase_voltage !== 12'd800) begin errors++; $display("FAIL latency pv value: got %0d expected 800", o_phase_voltage); end
    @(negedge clk);
    checks++;
    if (o_update_valid !== 1'b0) begin errors++; $display("FAIL latency pulse width: uv got %b expected 0", o_update_valid); end
  endtask

  task automatic test_integral();
    int exp_pv[3] = '{0, 10, 20};
    bit ok;
    disable_loop();
    checks += 2;
    if (o_phase_voltage !== 12'd0) begin errors++; $display("FAIL integral disable pv: got %0d expected 0", o_phase_voltage); end
    if (o_ref_eff !== 12'd0) begin errors++; $display("FAIL integral disable ref: got %0d expected 0", o_ref_eff); end
    set_inputs(100, 90, 0, 0);
    enable = 1'b1;
    for (int n = 0; n < 2; n++) run_loop_checked("integral settle");
    ki = 8'd16;
    for (int n = 0; n < 3; n++) begin
      wait_update(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL integral timeout on loop %0d", n);
      end else begin
        model_loop(100, 90, 0, 16);
        checks++;
        if (o_phase_voltage !== 12'(exp_pv[n])) begin
          errors++;
          $display("FAIL integral loop %0d pv: got %0d expected %0d", n, o_phase_voltage, exp_pv[n]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int guard;
    disable_loop();
    set_inputs(4095, 0, 0, 0);
    enable = 1'b1;
    guard = 0;
    while (m_ref != 4095 && guard < 80) begin
      run_loop_checked("sat settle");
      guard++;
    end
    kp = 8'd255;
    ki = 8'd16;
    for (int n = 0; n < 10; n++) run_loop_checked("saturation");
    checks++;
    if (o_phase_voltage !== 12'd4095) begin errors++; $display("FAIL saturation pv: got %0d expected 4095", o_phase_voltage); end
    // With both gains zero the drive equals the integrator, which must
    // still be zero after ten saturated loops.
    kp = 8'd0;
    ki = 8'd0;
    run_loop_checked("antiwindup");
    checks++;
    if (o_phase_voltage !== 12'd0) begin errors++; $display("FAIL antiwindup integrator: pv got %0d expected 0", o_phase_voltage); end
  endtask

  task automatic test_random();
    disable_loop();
    set_inputs(int'($urandom_range(0, 4095)), OVS, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    enable = 1'b1;
    for (int n = 0; n < 24; n++) begin
      run_loop_checked("random");
      checks++;
      if (o_fault !== 1'b0) begin errors++; $display("FAIL random fault: got %b expected 0 (speed %0d)", o_fault, motor_speed); end
      set_inputs(int'($urandom_range(0, 4095)), int'($urandom_range(0, OVS)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
  endtask

  task automatic test_fault();
    bit ok;
    int uv_seen;
    disable_loop();
    set_inputs(500, 0, 16, 0);
    enable = 1'b1;
    for (int n = 0; n < 8; n++) run_loop_checked("fault prep");
    motor_speed = 12'(OVS + 1);
    ok = 1'b0;
    uv_seen = 0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (o_update_valid) uv_seen++;
      if (o_fault) begin ok = 1'b1; break; end
    end
    checks += 6;
    if (!ok) begin errors++; $display("FAIL fault timeout: fault never set"); end
    if (uv_seen != 0) begin errors++; $display("FAIL fault uv: got %0d pulses expected 0", uv_seen); end
    if (o_phase_voltage !== 12'd0) begin errors++; $display("FAIL fault pv: got %0d expected 0", o_phase_voltage); end
    if (o_ref_eff !== 12'd0) begin errors++; $display("FAIL fault ref_eff: got %0d expected 0", o_ref_eff); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL fault busy: got %b expected 0", o_busy); end
    if (o_state !== ST_FAULT) begin errors++; $display("FAIL fault state: got %0d expected FAULT", o_state); end
    fault_clr = 1'b1;
    uv_seen = 0;
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      if (o_update_valid) uv_seen++;
    end
    checks += 2;
    if (o_fault !== 1'b1) begin errors++; $display("FAIL fault clr while enabled: fault got %b expected 1", o_fault); end
    if (uv_seen != 0) begin errors++; $display("FAIL fault ticks: got %0d pulses expected 0", uv_seen); end
    fault_clr = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (o_fault !== 1'b1) begin errors++; $display("FAIL fault disable only: fault got %b expected 1", o_fault); end
    fault_clr = 1'b1;
    @(negedge clk);
    checks += 2;
    if (o_fault !== 1'b0) begin errors++; $display("FAIL fault clear: fault got %b expected 0", o_fault); end
    if (o_state !== ST_IDLE) begin errors++; $display("FAIL fault exit state: got %0d expected IDLE", o_state); end
    fault_clr = 1'b0;
    model_clear();
  endtask

  task automatic test_abort();
    bit ok;
    int uv_seen;
    set_inputs(300, 0, 16, 0);
    enable = 1'b1;
    for (int n = 0; n < 5; n++) run_loop_checked("abort prep");
    wait_state(ST_MULP, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort timeout: MULP never reached"); end
    enable = 1'b0;
    @(negedge clk);
    checks += 4;
    if (o_state !== ST_IDLE) begin errors++; $display("FAIL abort state: got %0d expected IDLE", o_state); end
    if (o_phase_voltage !== 12'd0) begin errors++; $display("FAIL abort pv: got %0d expected 0", o_phase_voltage); end
    if (o_ref_eff !== 12'd0) begin errors++; $display("FAIL abort ref_eff: got %0d expected 0", o_ref_eff); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b expected 0", o_busy); end
    uv_seen = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clk);
      if (o_update_valid) uv_seen++;
    end
    checks++;
    if (uv_seen != 0) begin errors++; $display("FAIL abort uv: got %0d pulses expected 0", uv_seen); end
    model_clear();
  endtask

  task automatic test_async_reset();
    bit ok;
    set_inputs(300, 0, 16, 0);
    enable = 1'b1;
    for (int n = 0; n < 5; n++) run_loop_checked("reset prep");
    wait_state(ST_SUM, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL async reset timeout: SUM never reached"); end
    #2 rst = 1'b1;
    #1;
    checks += 5;
    if (o_phase_voltage !== 12'd0) begin errors++; $display("FAIL async reset pv: got %0d expected 0", o_phase_voltage); end
    if (o_ref_eff !== 12'd0) begin errors++; $display("FAIL async reset ref_eff: got %0d expected 0", o_ref_eff); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL async reset busy: got %b expected 0", o_busy); end
    if (o_update_valid !== 1'b0) begin errors++; $display("FAIL async reset uv: got %b expected 0", o_update_valid); end
    if (o_state !== ST_IDLE) begin errors++; $display("FAIL async reset state: got %0d expected IDLE", o_state); end
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    model_clear();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_slew();
    test_latency();
    test_integral();
    test_saturation();
    test_random();
    test_fault();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
